// File: rtl/apb5_reg_completer.sv
// -----------------------------------------------------------------------------
// apb5_reg_completer
//
// APB5 completer in front of a bank of 32-bit control/status registers.
// Every transfer gets WAIT_STATES cycles of PREADY low before a single PREADY
// high cycle. Writes honour byte strobes. Each register has a USER_DATA_WIDTH
// user field: a write with any strobe set stores PWUSER there, and a read
// returns it on PRUSER. Decode errors raise PSLVERR and put an error code on
// PBUSER.
//
// Optional feature (macro APB_REG_PROT_CHECK_EN):
//   When defined, an unprivileged access (pprot[0] = 0) to the upper half of
//   the bank is a protection error (PBUSER = 2'b11).
//   When undefined, pprot is ignored.
//
// Ports:
//   pclk, presetn         clock, asynchronous active-low reset
//   psel, penable, pwrite APB control
//   paddr                 byte address; word index is paddr[ADDR_WIDTH-1:2]
//   pwdata, pstrb         write data, byte strobes
//   pprot                 protection; bit 0 = privileged
//   pwuser                write-data user bits
//   pready, pslverr       completer ready, transfer error (registered)
//   prdata, pruser        read data, read-data user bits (registered)
//   pbuser                response code: 00 ok, 01 range, 10 misaligned,
//                         11 protection; upper bits are 0 (registered)
//   regs_o                flattened register bank; reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   state_o               FSM state for observation: 0 IDLE, 1 SETUP_SEEN, 2 ACCESS
//
// Handshake:
//   A transfer starts with a setup cycle (psel=1, penable=0) seen while IDLE.
//   It completes on the first edge where psel, penable and pready are all
//   high. Dropping psel before that edge aborts the transfer: nothing is
//   written and the response outputs are cleared. prdata, pruser, pslverr
//   and pbuser become valid with pready. They hold until the next setup edge.
// -----------------------------------------------------------------------------
module apb5_reg_completer #(
   parameter int ADDR_WIDTH      = 12,
   parameter int DATA_WIDTH      = 32,
   parameter int NUM_REGS        = 16,
   parameter int WAIT_STATES     = 1,
   parameter int USER_DATA_WIDTH = 8,
   parameter int USER_RESP_WIDTH = 2
) (
   input  logic                           pclk,
   input  logic                           presetn,
   input  logic                           psel,
   input  logic                           penable,
   input  logic                           pwrite,
   input  logic [ADDR_WIDTH-1:0]          paddr,
   input  logic [DATA_WIDTH-1:0]          pwdata,
   input  logic [DATA_WIDTH/8-1:0]        pstrb,
   input  logic [2:0]                     pprot,
   input  logic [USER_DATA_WIDTH-1:0]     pwuser,
   output logic                           pready,
   output logic [DATA_WIDTH-1:0]          prdata,
   output logic                           pslverr,
   output logic [USER_DATA_WIDTH-1:0]     pruser,
   output logic [USER_RESP_WIDTH-1:0]     pbuser,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
   output logic [1:0]                     state_o
);

   localparam int IW = ADDR_WIDTH - 2;
   localparam int XW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int SW = DATA_WIDTH / 8;

   localparam logic [IW-1:0] NREG_I = IW'(NUM_REGS);
   localparam logic [IW-1:0] HALF_I = IW'(NUM_REGS / 2);
   localparam logic [3:0]    WS_C   = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_SETUP_SEEN = 2'd1,
      S_ACCESS     = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   // Transfer captured at the setup edge
   logic                       wr_q;
   logic [XW-1:0]              idx_q;
   logic [SW-1:0]              strb_q;
   logic [DATA_WIDTH-1:0]      wdata_q;
   logic [USER_DATA_WIDTH-1:0] wuser_q;
   logic [1:0]                 err_q;

   // Register bank and per-register user bits
   logic [DATA_WIDTH-1:0]      regs_q [NUM_REGS];
   logic [USER_DATA_WIDTH-1:0] user_q [NUM_REGS];

   // Registered response outputs
   logic                       pready_q;
   logic                       pslverr_q;
   logic [DATA_WIDTH-1:0]      prdata_q;
   logic [USER_DATA_WIDTH-1:0] pruser_q;
   logic [USER_RESP_WIDTH-1:0] pbuser_q;

   // ---------------------------------------------------------------------------
   // Address decode of the live setup-phase inputs
   // ---------------------------------------------------------------------------
   logic [IW-1:0] set_idx;
   logic [1:0]    set_err;
   logic          unused_prot;

   assign set_idx     = paddr[ADDR_WIDTH-1:2];
   assign unused_prot = ^pprot;

   always_comb begin
      set_err = 2'b00;
      if (paddr[1:0] != 2'b00) begin
         set_err = 2'b10;
      end else if (set_idx >= NREG_I) begin
         set_err = 2'b01;
      end
`ifdef APB_REG_PROT_CHECK_EN
      else if (!pprot[0] && (set_idx >= HALF_I)) begin
         set_err = 2'b11;
      end
`endif
   end

   // ---------------------------------------------------------------------------
   // Response source. With WAIT_STATES = 0 the response is loaded at the
   // setup edge itself, before anything has been captured. In that case it
   // comes from the live inputs. Otherwise it comes from the captured transfer.
   // ---------------------------------------------------------------------------
   logic                       r_wr;
   logic [1:0]                 r_err;
   logic [XW-1:0]              r_idx;
   logic [DATA_WIDTH-1:0]      resp_rdata;
   logic [USER_DATA_WIDTH-1:0] resp_ruser;

   always_comb begin
      r_wr       = wr_q;
      r_err      = err_q;
      r_idx      = idx_q;
      if (state_q == S_IDLE) begin
         r_wr  = pwrite;
         r_err = set_err;
         r_idx = set_idx[XW-1:0];
      end
      resp_rdata = '0;
      resp_ruser = '0;
      if (!r_wr && (r_err == 2'b00)) begin
         resp_rdata = regs_q[r_idx];
         resp_ruser = user_q[r_idx];
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next state and control strobes
   // ---------------------------------------------------------------------------
   logic setup_fire, active, abort, complete, tick, resp_load;

   always_comb begin
      setup_fire = (state_q == S_IDLE) && psel && !penable;
      active     = (state_q != S_IDLE);
      abort      = active && !psel;
      complete   = active && psel && penable && pready_q;
      tick       = active && psel && !pready_q && (cnt_q != 4'd0);
      resp_load  = (setup_fire && (WS_C == 4'd0)) || (tick && (cnt_q == 4'd1));

      cnt_d = cnt_q;
      if (setup_fire) begin
         cnt_d = WS_C;
      end else if (tick) begin
         cnt_d = cnt_q - 4'd1;
      end

      state_d = state_q;
      case (state_q)
         S_IDLE:       if (setup_fire) state_d = S_SETUP_SEEN;
         // With no wait states the transfer can already complete here.
         S_SETUP_SEEN: state_d = (abort || complete) ? S_IDLE : S_ACCESS;
         S_ACCESS:     if (abort || complete) state_d = S_IDLE;
         default:      state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State, capture, response and register bank
   // ---------------------------------------------------------------------------
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         wr_q      <= 1'b0;
         idx_q     <= '0;
         strb_q    <= '0;
         wdata_q   <= '0;
         wuser_q   <= '0;
         err_q     <= 2'b00;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
         pruser_q  <= '0;
         pbuser_q  <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
            user_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;

         if (setup_fire) begin
            wr_q      <= pwrite;
            idx_q     <= set_idx[XW-1:0];
            strb_q    <= pstrb;
            wdata_q   <= pwdata;
            wuser_q   <= pwuser;
            err_q     <= set_err;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            pruser_q  <= '0;
            pbuser_q  <= '0;
         end

         if (resp_load) begin
            pready_q  <= 1'b1;
            pslverr_q <= (r_err != 2'b00);
            pbuser_q  <= USER_RESP_WIDTH'(r_err);
            prdata_q  <= resp_rdata;
            pruser_q  <= resp_ruser;
         end

         if (complete) begin
            pready_q <= 1'b0;
            if (wr_q && (err_q == 2'b00)) begin
               for (int k = 0; k < SW; k++) begin
                  if (strb_q[k]) regs_q[idx_q][k*8 +: 8] <= wdata_q[k*8 +: 8];
               end
               if (|strb_q) user_q[idx_q] <= wuser_q;
            end
         end

         if (abort) begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            pbuser_q  <= '0;
         end
      end
   end

   assign pready  = pready_q;
   assign pslverr = pslverr_q;
   assign prdata  = prdata_q;
   assign pruser  = pruser_q;
   assign pbuser  = pbuser_q;
   assign state_o = state_q;

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_out
      assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
   end

endmodule

// File: tb/tb_apb5_reg_completer.sv
// -----------------------------------------------------------------------------
// tb_apb5_reg_completer
//
// Directed bench for apb5_reg_completer (WAIT_STATES = 1).
// - A driver task issues each transfer and pushes its expected response
//   {pslverr, pbuser, prdata, pruser} into exp_q.
// - A monitor pops exp_q and compares whenever pready is high.
// - Register contents, abort and reset behaviour are checked directly.
// -----------------------------------------------------------------------------
module tb_apb5_reg_completer;

   localparam int AW  = 12;
   localparam int DW  = 32;
   localparam int NR  = 16;
   localparam int WS  = 1;
   localparam int UDW = 8;
   localparam int URW = 2;
   localparam int RW  = 1 + URW + DW + UDW;

   logic             pclk;
   logic             presetn;
   logic             psel;
   logic             penable;
   logic             pwrite;
   logic [AW-1:0]    paddr;
   logic [DW-1:0]    pwdata;
   logic [DW/8-1:0]  pstrb;
   logic [2:0]       pprot;
   logic [UDW-1:0]   pwuser;
   logic             pready;
   logic [DW-1:0]    prdata;
   logic             pslverr;
   logic [UDW-1:0]   pruser;
   logic [URW-1:0]   pbuser;
   logic [NR*DW-1:0] regs_o;
   logic [1:0]       state_o;

   apb5_reg_completer #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_STATES(WS),
      .USER_DATA_WIDTH(UDW), .USER_RESP_WIDTH(URW)
   ) dut (
      .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
      .pprot(pprot), .pwuser(pwuser), .pready(pready), .prdata(prdata),
      .pslverr(pslverr), .pruser(pruser), .pbuser(pbuser), .regs_o(regs_o),
      .state_o(state_o)
   );

   // ---------------------------------------------------------------------------
   // Clock
   // ---------------------------------------------------------------------------
   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // ---------------------------------------------------------------------------
   // Scoreboard state
   // ---------------------------------------------------------------------------
   int checks = 0;
   int errors = 0;
   logic [RW-1:0] exp_q[$];
   logic [RW-1:0] mon_act;
   logic [RW-1:0] mon_exp;

   function automatic logic [RW-1:0] resp(input logic err, input logic [URW-1:0] code,
                                          input logic [DW-1:0] d, input logic [UDW-1:0] u);
      return {err, code, d, u};
   endfunction

   function automatic logic [DW-1:0] reg_at(input int i);
      return regs_o[i*DW +: DW];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Monitor: every pready-high sample must match the oldest expected response
   // ---------------------------------------------------------------------------
   always @(negedge pclk) begin
      if (presetn && pready) begin
         mon_act = {pslverr, pbuser, prdata, pruser};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL resp_unexpected actual=%h expected=none", mon_act);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_act !== mon_exp) begin
               errors++;
               $display("FAIL resp actual={err %b code %b data %h user %h} expected={err %b code %b data %h user %h}",
                        mon_act[RW-1], mon_act[RW-2 -: URW], mon_act[UDW +: DW], mon_act[UDW-1:0],
                        mon_exp[RW-1], mon_exp[RW-2 -: URW], mon_exp[UDW +: DW], mon_exp[UDW-1:0]);
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Driver tasks. Called at posedge+#1. Each returns at posedge+#1 after the
   // completion edge with the bus idle, so a back-to-back call drives the next
   // setup cycle immediately.
   // ---------------------------------------------------------------------------
   task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input logic [3:0] strb, input logic [2:0] prot,
                       input logic [UDW-1:0] wuser, input logic [RW-1:0] exp);
      int  n;
      bit  got;
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = wdata;
      pstrb   = strb;
      pprot   = prot;
      pwuser  = wuser;
      exp_q.push_back(exp);
      @(posedge pclk);
      #1 penable = 1'b1;
      n   = 0;
      got = 1'b0;
      while (!got && n < 20) begin
         @(negedge pclk);
         n++;
         if (pready) got = 1'b1;
      end
      checks++;
      if (!got || n != WS + 1) begin
         errors++;
         $display("FAIL pready_latency addr=%h actual=%0d got=%0d expected=%0d", addr, n, got, WS + 1);
      end
      @(posedge pclk);
      #1;
      psel    = 1'b0;
      penable = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge pclk);
         #1;
      end
   endtask

   logic [RW-1:0] prot_exp;
   logic [DW-1:0] reg8_exp;

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      presetn = 1'b0;
      psel    = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = '0;
      pwdata  = '0;
      pstrb   = '0;
      pprot   = 3'b001;
      pwuser  = '0;
      #23 presetn = 1'b1;
      @(posedge pclk);
      #1;

      // Reset state
      check("rst_pready",  pready,  0);
      check("rst_pslverr", pslverr, 0);
      check("rst_prdata",  prdata,  0);
      check("rst_pruser",  pruser,  0);
      check("rst_pbuser",  pbuser,  0);
      check("rst_state",   state_o, 0);
      for (int i = 0; i < NR; i++) check($sformatf("rst_reg%0d", i), reg_at(i), 0);

      // Full write, then read back data and user bits
      xfer(1, 12'h004, 32'hDEADBEEF, 4'hF, 3'b001, 8'h5A, resp(0, 2'b00, 0, 0));
      check("wr_full_reg1", reg_at(1), 32'hDEADBEEF);
      idle(1);
      xfer(0, 12'h004, 0, 4'h0, 3'b001, 8'h00, resp(0, 2'b00, 32'hDEADBEEF, 8'h5A));
      @(negedge pclk);
      check("rd_hold_prdata", prdata, 32'hDEADBEEF);
      check("rd_hold_pready", pready, 0);
      #6;

      // Partial strobes: bytes 0 and 2 only
      xfer(1, 12'h004, 32'h11223344, 4'b0101, 3'b001, 8'h33, resp(0, 2'b00, 0, 0));
      check("wr_strb_reg1", reg_at(1), 32'hDE22BE44);
      idle(1);
      xfer(0, 12'h004, 0, 4'h0, 3'b001, 8'h00, resp(0, 2'b00, 32'hDE22BE44, 8'h33));
      idle(1);

      // Decode errors: out of range, misaligned read, misaligned write
      xfer(0, 12'h040, 0, 4'h0, 3'b001, 8'h00, resp(1, 2'b01, 0, 0));
      idle(1);
      xfer(0, 12'h006, 0, 4'h0, 3'b001, 8'h00, resp(1, 2'b10, 0, 0));
      idle(1);
      xfer(1, 12'h006, 32'h0, 4'hF, 3'b001, 8'hEE, resp(1, 2'b10, 0, 0));
      check("wr_misaligned_reg1", reg_at(1), 32'hDE22BE44);
      idle(1);

      // Protection: unprivileged write to the upper half of the bank
`ifdef APB_REG_PROT_CHECK_EN
      prot_exp = resp(1, 2'b11, 0, 0);
      reg8_exp = 32'h0;
`else
      prot_exp = resp(0, 2'b00, 0, 0);
      reg8_exp = 32'h1;
`endif
      xfer(1, 12'h020, 32'h1, 4'hF, 3'b000, 8'h11, prot_exp);
      check("wr_unpriv_reg8", reg_at(8), reg8_exp);
      idle(1);
      xfer(1, 12'h020, 32'h1, 4'hF, 3'b001, 8'h22, resp(0, 2'b00, 0, 0));
      check("wr_priv_reg8", reg_at(8), 32'h1);
      idle(1);
      xfer(0, 12'h020, 0, 4'h0, 3'b001, 8'h00, resp(0, 2'b00, 32'h1, 8'h22));
      idle(1);

      // No strobes: neither data nor user bits change
      xfer(1, 12'h00C, 32'hFFFFFFFF, 4'h0, 3'b001, 8'h77, resp(0, 2'b00, 0, 0));
      check("wr_nostrb_reg3", reg_at(3), 0);
      idle(1);
      xfer(0, 12'h00C, 0, 4'h0, 3'b001, 8'h00, resp(0, 2'b00, 0, 0));

      // Back-to-back write then read of the same register (no idle cycle)
      xfer(1, 12'h03C, 32'hA5A50F0F, 4'hF, 3'b001, 8'hC3, resp(0, 2'b00, 0, 0));
      xfer(0, 12'h03C, 0, 4'h0, 3'b001, 8'h00, resp(0, 2'b00, 32'hA5A50F0F, 8'hC3));
      check("b2b_reg15", reg_at(15), 32'hA5A50F0F);
      idle(1);

      // Abort: drop psel during the wait state of a write to 0x008
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 12'h008;
      pwdata  = 32'hCAFEF00D;
      pstrb   = 4'hF;
      pprot   = 3'b001;
      pwuser  = 8'h99;
      @(posedge pclk);
      #1 penable = 1'b1;
      @(negedge pclk);
      check("abort_waitstate_pready", pready, 0);
      psel    = 1'b0;
      penable = 1'b0;
      @(posedge pclk);
      #1;
      check("abort_state_idle", state_o, 0);
      check("abort_pready",     pready,  0);
      check("abort_pslverr",    pslverr, 0);
      idle(2);
      check("abort_reg2", reg_at(2), 0);
      xfer(0, 12'h008, 0, 4'h0, 3'b001, 8'h00, resp(0, 2'b00, 0, 0));
      idle(1);

      // Reset asserted in the middle of a write access
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 12'h004;
      pwdata  = 32'h00000000;
      pstrb   = 4'hF;
      pwuser  = 8'h00;
      @(posedge pclk);
      #1 penable = 1'b1;
      #2 presetn = 1'b0;
      #1;
      check("midrst_pready",  pready,  0);
      check("midrst_pslverr", pslverr, 0);
      check("midrst_prdata",  prdata,  0);
      check("midrst_pruser",  pruser,  0);
      check("midrst_pbuser",  pbuser,  0);
      check("midrst_state",   state_o, 0);
      check("midrst_reg1",    reg_at(1),  0);
      check("midrst_reg15",   reg_at(15), 0);
      psel    = 1'b0;
      penable = 1'b0;
      @(posedge pclk);
      #1 presetn = 1'b1;
      idle(1);
      xfer(0, 12'h004, 0, 4'h0, 3'b001, 8'h00, resp(0, 2'b00, 0, 0));
      idle(2);

      // Every pushed response must have been consumed
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1);
      check("exp_q_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
